// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with pending (scoreboard) bits
// x0 reads as zero; optional same-cycle write-to-read forwarding.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NRD-1:0]      rd_busy
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;

  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [AW-1:0]    wa;
  logic [AW-1:0]    ra;

  // Later ports overwrite earlier ones, so the highest enabled port wins.
  always_comb begin
    wr_hit = '0;
    wa     = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = '0;
    end
    for (int k = 0; k < NWR; k++) begin
      wa = wr_addr[k*AW +: AW];
      if (wr_en[k] && (wa != '0)) begin
        wr_hit[wa] = 1'b1;
        wr_val[wa] = wr_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = rd_addr[j*AW +: AW];
      if (ra != '0) begin
        if ((BYPASS != 0) && wr_hit[ra]) begin
          rd_data[j*XLEN +: XLEN] = wr_val[ra];
          rd_busy[j]              = 1'b0;
        end else begin
          rd_data[j*XLEN +: XLEN] = regs[ra];
          rd_busy[j]              = pending[ra];
        end
      end
    end
  end

  // A reserve beats a same-cycle write: the write retires the old producer,
  // the reserve registers a new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      pending <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
        if (rsv_en && (rsv_addr == AW'(r))) begin
          pending[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          pending[r] <= 1'b0;
        end
      end
      pending[0] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - bench for reg_file_mp, bypass and non-bypass instances
// Directed vector table, hand sequences for reset, then random vs. model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [4:0]  ra [2];
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [9:0]  wr_addr_bus;
  logic [63:0] wr_data_bus;
  logic [9:0]  rd_addr_bus;
  logic [63:0] rd_data_b1, rd_data_b0;
  logic [1:0]  rd_busy_b1, rd_busy_b0;

  assign wr_addr_bus = {wa[1], wa[0]};
  assign wr_data_bus = {wd[1], wd[0]};
  assign rd_addr_bus = {ra[1], ra[0]};

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr_bus), .wr_data(wr_data_bus),
    .rd_addr(rd_addr_bus), .rd_data(rd_data_b1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_busy(rd_busy_b1)
  );

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr_bus), .wr_data(wr_data_bus),
    .rd_addr(rd_addr_bus), .rd_data(rd_data_b0), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_busy(rd_busy_b0)
  );

  int checks = 0;
  int errors = 0;

  // Architectural view of the register file
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_regs[a];
    if (byp)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wa[k] == a) v = wd[k];
    return v;
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
    bit b;
    if (a == 5'd0) return 32'd0;
    b = m_pend[a];
    if (byp)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wa[k] == a) b = 1'b0;
    return {31'd0, b};
  endfunction

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 32'd0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wa[k] != 5'd0) begin
          m_regs[wa[k]] = wd[k];
          m_pend[wa[k]] = 1'b0;
        end
      if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 2'b00; rsv_en = 1'b0; rsv_addr = 5'd0;
    wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'd0; wd[1] = 32'd0;
  endtask

  typedef struct {
    logic        rsv;
    logic [4:0]  rsva;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e1d0, e1d1;
    logic [1:0]  e1b;
    logic [31:0] e0d0, e0d1;
    logic [1:0]  e0b;
  } vec_t;

  vec_t vt [17];

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_pend[r] = 1'b0;
    end
    //          rsv  rsva  we     wa0 wa1 wd0           wd1    ra0 ra1 e1d0          e1d1   e1b    e0d0          e0d1   e0b
    vt[0]  = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     5,  31, 0,            0,     2'b00, 0,            0,     2'b00};
    vt[1]  = '{1'b0, 5'd0, 2'b01, 5,  0,  32'hDEADBEEF, 0,     5,  0,  32'hDEADBEEF, 0,     2'b00, 0,            0,     2'b00};
    vt[2]  = '{1'b0, 5'd0, 2'b01, 0,  0,  32'h1234,     0,     5,  0,  32'hDEADBEEF, 0,     2'b00, 32'hDEADBEEF, 0,     2'b00};
    vt[3]  = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     0,  5,  0,            32'hDEADBEEF, 2'b00, 0,     32'hDEADBEEF, 2'b00};
    vt[4]  = '{1'b0, 5'd0, 2'b11, 7,  7,  32'h11,       32'h22, 7, 7,  32'h22,       32'h22, 2'b00, 0,           0,     2'b00};
    vt[5]  = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     7,  7,  32'h22,       32'h22, 2'b00, 32'h22,      32'h22, 2'b00};
    vt[6]  = '{1'b0, 5'd0, 2'b10, 0,  3,  0,            32'hA, 3,  3,  32'hA,        32'hA, 2'b00, 0,            0,     2'b00};
    vt[7]  = '{1'b0, 5'd0, 2'b01, 3,  0,  32'hB,        0,     3,  0,  32'hB,        0,     2'b00, 32'hA,        0,     2'b00};
    vt[8]  = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     3,  0,  32'hB,        0,     2'b00, 32'hB,        0,     2'b00};
    vt[9]  = '{1'b1, 5'd9, 2'b00, 0,  0,  0,            0,     9,  9,  0,            0,     2'b00, 0,            0,     2'b00};
    vt[10] = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     9,  0,  0,            0,     2'b01, 0,            0,     2'b01};
    vt[11] = '{1'b0, 5'd0, 2'b01, 9,  0,  32'h55,       0,     9,  9,  32'h55,       32'h55, 2'b00, 0,           0,     2'b11};
    vt[12] = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     9,  0,  32'h55,       0,     2'b00, 32'h55,       0,     2'b00};
    vt[13] = '{1'b1, 5'd9, 2'b10, 0,  9,  0,            32'h66, 9, 9,  32'h66,       32'h66, 2'b00, 32'h55,      32'h55, 2'b00};
    vt[14] = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     9,  0,  32'h66,       0,     2'b01, 32'h66,       0,     2'b01};
    vt[15] = '{1'b1, 5'd0, 2'b00, 0,  0,  0,            0,     0,  0,  0,            0,     2'b00, 0,            0,     2'b00};
    vt[16] = '{1'b0, 5'd0, 2'b00, 0,  0,  0,            0,     0,  9,  0,            32'h66, 2'b10, 0,           32'h66, 2'b10};

    idle();
    ra[0] = 5'd0; ra[1] = 5'd0;
    rst = 1'b1;
    advance();
    advance();
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      idle();
      rsv_en = vt[i].rsv; rsv_addr = vt[i].rsva; wr_en = vt[i].we;
      wa[0] = vt[i].wa0; wa[1] = vt[i].wa1; wd[0] = vt[i].wd0; wd[1] = vt[i].wd1;
      ra[0] = vt[i].ra0; ra[1] = vt[i].ra1;
      @(negedge clk);
      chk($sformatf("vec%0d_b1_d0", i), rd_data_b1[31:0],  vt[i].e1d0);
      chk($sformatf("vec%0d_b1_d1", i), rd_data_b1[63:32], vt[i].e1d1);
      chk($sformatf("vec%0d_b1_busy", i), {30'd0, rd_busy_b1}, {30'd0, vt[i].e1b});
      chk($sformatf("vec%0d_b0_d0", i), rd_data_b0[31:0],  vt[i].e0d0);
      chk($sformatf("vec%0d_b0_d1", i), rd_data_b0[63:32], vt[i].e0d1);
      chk($sformatf("vec%0d_b0_busy", i), {30'd0, rd_busy_b0}, {30'd0, vt[i].e0b});
      advance();
    end

    // Fill x1..x31, reserve x4, then reset together with a write to x2
    for (int r = 1; r < 32; r++) begin
      idle();
      wr_en[r % 2] = 1'b1;
      wa[r % 2] = 5'(r);
      wd[r % 2] = r * 32'h01010101;
      advance();
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    advance();
    idle();
    rst = 1'b1; wr_en = 2'b01; wa[0] = 5'd2; wd[0] = 32'h99;
    ra[0] = 5'd2; ra[1] = 5'd4;
    @(negedge clk);
    chk("rst_cycle_b1_d0", rd_data_b1[31:0], 32'h99);
    chk("rst_cycle_b1_d1", rd_data_b1[63:32], 32'h04040404);
    chk("rst_cycle_b1_busy", {30'd0, rd_busy_b1}, 32'd2);
    chk("rst_cycle_b0_d0", rd_data_b0[31:0], 32'h02020202);
    chk("rst_cycle_b0_busy", {30'd0, rd_busy_b0}, 32'd2);
    advance();
    idle();
    for (int i = 0; i < 16; i++) begin
      ra[0] = 5'(2 * i); ra[1] = 5'(2 * i + 1);
      @(negedge clk);
      chk($sformatf("post_rst_b1_d_x%0d", 2 * i), rd_data_b1[31:0] | rd_data_b1[63:32], 32'd0);
      chk($sformatf("post_rst_b0_d_x%0d", 2 * i), rd_data_b0[31:0] | rd_data_b0[63:32], 32'd0);
      chk($sformatf("post_rst_busy_x%0d", 2 * i), {28'd0, rd_busy_b1, rd_busy_b0}, 32'd0);
      advance();
    end

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      wr_en = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        wa[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wd[k] = $urandom;
        ra[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("rnd%0d_b1_d%0d", n, j), rd_data_b1[j*32 +: 32], exp_data(ra[j], 1'b1));
        chk($sformatf("rnd%0d_b1_busy%0d", n, j), {31'd0, rd_busy_b1[j]}, exp_busy(ra[j], 1'b1));
        chk($sformatf("rnd%0d_b0_d%0d", n, j), rd_data_b0[j*32 +: 32], exp_data(ra[j], 1'b0));
        chk($sformatf("rnd%0d_b0_busy%0d", n, j), {31'd0, rd_busy_b0[j]}, exp_busy(ra[j], 1'b0));
      end
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers; a power of two, at least 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports, at least 1.
REQ-004 SHALL have parameter NWR, default 2, number of write ports, at least 1.
REQ-005 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads; 0 gives stored values only.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-008 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-009 SHALL have port wr_addr  input  NWR*AW  per-port destination index; port k occupies bits [k*AW +: AW].
REQ-010 SHALL have port wr_data  input  NWR*XLEN  per-port write data; port k occupies bits [k*XLEN +: XLEN].
REQ-011 SHALL have port rd_addr  input  NRD*AW  per-port source index.
REQ-012 SHALL have port rd_data  output  NRD*XLEN  per-port read data, combinational from rd_addr and state.
REQ-013 SHALL have port rsv_en  input  1  reserve request: marks a register as pending a future write.
REQ-014 SHALL have port rsv_addr  input  AW  index of the register to reserve.
REQ-015 SHALL have port rd_busy  output  NRD  per-read-port pending flag for rd_addr, combinational.

Function
REQ-016 SHALL hold NREGS x XLEN data registers plus NREGS pending bits.
REQ-017 SHALL treat register 0 as hardwired zero: reads return 0, busy reads 0, and writes and reserves to index 0 have no effect.
REQ-018 SHALL, on a rising edge with wr_en[k]=1 and wr_addr[k]!=0, store wr_data[k] into that register; write latency is 1 cycle.
REQ-019 SHALL resolve several enabled write ports targeting the same index in one cycle by highest port index wins; losing data is discarded.
REQ-020 SHALL, when BYPASS=1, drive rd_data[j] with the winning same-cycle wr_data for rd_addr[j] if one exists, otherwise with the stored value.
REQ-021 SHALL, when BYPASS=0, drive rd_data[j] only from the stored value; new data becomes visible in the cycle after the write edge.
REQ-022 SHALL set pending[rsv_addr] on a rising edge with rsv_en=1 and rsv_addr!=0.
REQ-023 SHALL clear pending[r] on a rising edge where any enabled write port targets r.
REQ-024 SHALL let a reserve win over a write to the same index in the same cycle: data is written and pending ends set, because a new producer has been issued.
REQ-025 SHALL, when BYPASS=1, drive rd_busy[j] as 0 when the stored pending bit is set and a same-cycle write targets rd_addr[j]; otherwise it equals the stored pending bit.
REQ-026 SHALL, when BYPASS=0, drive rd_busy[j] as the stored pending bit only.
REQ-027 SHALL NOT reflect a same-cycle reserve in rd_busy; a reserve becomes visible the cycle after its edge.
REQ-028 SHALL treat all read ports independently; any number of ports may read the same index.

Reset
REQ-029 SHALL, on a rising edge with rst=1, clear all data registers and all pending bits to 0.
REQ-030 SHALL give rst priority over writes and reserves in the same cycle; those requests are dropped.
REQ-031 SHALL, after reset, read rd_data=0 and rd_busy=0 on every port until the next write or reserve.
REQ-032 SHALL still apply same-cycle bypass with BYPASS=1 while rst=1; only stored state is reset.

Verification
REQ-033 Bench SHALL run: write x5=0xDEADBEEF on port 0; next cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF; a write of 0x1234 to x0 -> reading x0 returns 0.
REQ-034 Bench SHALL run: in one cycle port 0 writes x7=0x11 and port 1 writes x7=0x22 -> rd_data for x7 = 0x22 that cycle (BYPASS=1) and afterwards.
REQ-035 Bench SHALL run: BYPASS=1 with x3=0xA, write x3=0xB while reading x3 -> 0xB the same cycle; BYPASS=0 -> 0xA that cycle, then 0xB.
REQ-036 Bench SHALL run: reserve x9 -> rd_busy=0 in the reserve cycle and 1 after; write x9=0x55 -> busy 0 in the write cycle (BYPASS=1), and busy stays 0 after.
REQ-037 Bench SHALL run: reserve and write x9 in the same cycle -> x9=write data and rd_busy=1 the next cycle.
REQ-038 Bench SHALL run: fill x1..x31 and reserve x4, then assert rst together with a write x2=0x99 -> all reads 0 and all busy 0 the next cycle.
